// File: rtl/fetch_defs.sv
// Shared fetch-unit definitions: word width, default reset PC and FSM state encoding.
package fetch_defs;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StKill = 2'd2,
    StFull = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry in-order instruction buffer with registered head outputs.
module fetch_buf
  import fetch_defs::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_enq,
  input  logic            i_deq,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_enq_pc,
  input  logic [XLEN-1:0] i_enq_instr,
  output logic [1:0]      o_count,
  output logic            o_valid,
  output logic [XLEN-1:0] o_head_pc,
  output logic [XLEN-1:0] o_head_instr
);

  logic [XLEN-1:0] r_pc    [2];
  logic [XLEN-1:0] r_instr [2];
  logic [1:0]      r_count;
  logic            r_valid;

  logic [XLEN-1:0] w_pc_d    [2];
  logic [XLEN-1:0] w_instr_d [2];
  logic [1:0]      w_count_d;
  logic            w_deq;
  logic            w_enq;
  logic            w_slot;

  always_comb begin
    w_deq     = i_deq && (r_count != 2'd0);
    w_enq     = i_enq && ((r_count != 2'd2) || w_deq);
    // Write slot is the first free entry after any same-cycle shift.
    w_slot    = (r_count == 2'd2) || ((r_count == 2'd1) && !w_deq);
    w_pc_d    = r_pc;
    w_instr_d = r_instr;
    w_count_d = r_count;
    if (i_flush) begin
      w_count_d = 2'd0;
    end else begin
      if (w_deq) begin
        w_pc_d[0]    = r_pc[1];
        w_instr_d[0] = r_instr[1];
      end
      if (w_enq) begin
        w_pc_d[w_slot]    = i_enq_pc;
        w_instr_d[w_slot] = i_enq_instr;
      end
      w_count_d = r_count + {1'b0, w_enq} - {1'b0, w_deq};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= '{default: '0};
      r_instr <= '{default: '0};
      r_count <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_d;
      r_instr <= w_instr_d;
      r_count <= w_count_d;
      r_valid <= (w_count_d != 2'd0);
    end
  end

  assign o_count      = r_count;
  assign o_valid      = r_valid;
  assign o_head_pc    = r_pc[0];
  assign o_head_instr = r_instr[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, request FSM and redirect handling in front of fetch_buf.
module fetch_unit
  import fetch_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [5:0]      op,
  output logic [5:0]      funct
);

  fetch_state_e    r_state;
  logic            r_req;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_target;

  logic            w_enq;
  logic            w_deq;
  logic            w_fill;
  logic [1:0]      w_count;
  logic [XLEN-1:0] w_redir_pc;

  assign w_redir_pc = word_align(redirect_pc);
  assign w_enq      = (r_state == StReq) && imem_ack && !redirect;
  assign w_deq      = instr_valid && instr_ready && !redirect;
  assign w_fill     = w_enq && (((w_count == 2'd1) && !w_deq) || ((w_count == 2'd2) && w_deq));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_req    <= 1'b0;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_state <= StReq;
          r_req   <= 1'b1;
          if (redirect) r_pc <= w_redir_pc;
        end
        StReq: begin
          if (redirect) begin
            if (imem_ack) begin
              r_pc <= w_redir_pc;
            end else begin
              // Request already on the bus: keep it stable and drop its data later.
              r_target <= w_redir_pc;
              r_state  <= StKill;
            end
          end else if (imem_ack) begin
            r_pc <= r_pc + 32'd4;
            if (w_fill) begin
              r_state <= StFull;
              r_req   <= 1'b0;
            end
          end
        end
        StKill: begin
          if (imem_ack) begin
            r_pc    <= redirect ? w_redir_pc : r_target;
            r_state <= StReq;
          end else if (redirect) begin
            r_target <= w_redir_pc;
          end
        end
        StFull: begin
          if (redirect) begin
            r_pc    <= w_redir_pc;
            r_state <= StReq;
            r_req   <= 1'b1;
          end else if (w_deq) begin
            r_state <= StReq;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  fetch_buf u_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enq        (w_enq),
    .i_deq        (w_deq),
    .i_flush      (redirect),
    .i_enq_pc     (r_pc),
    .i_enq_instr  (imem_rdata),
    .o_count      (w_count),
    .o_valid      (instr_valid),
    .o_head_pc    (instr_pc),
    .o_head_instr (instr)
  );

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign op        = instr[31:26];
  assign funct     = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random checks of fetch_unit against a queue-based fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [5:0]  op;
  logic [5:0]  funct;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .op          (op),
    .funct       (funct)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: next fetch address, pending kill target, and the buffered instructions in order.
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_started;
  bit          m_kill;
  logic [31:0] m_qpc[$];
  logic [31:0] m_qins[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %08h want %08h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_target = 32'h0; m_started = 0; m_kill = 0;
    m_qpc.delete(); m_qins.delete();
  endtask

  function automatic bit model_req();
    return m_started && (m_kill || (m_qpc.size() < 2));
  endfunction

  task automatic model_step();
    bit          req = model_req();
    bit          deq = (m_qpc.size() > 0) && instr_ready && !redirect;
    logic [31:0] rp  = redirect_pc & 32'hFFFF_FFFC;
    if (!m_started) begin
      m_started = 1;
      if (redirect) m_pc = rp;
    end else if (redirect) begin
      m_qpc.delete(); m_qins.delete();
      if (m_kill) begin
        if (imem_ack) begin m_pc = rp; m_kill = 0; end
        else m_target = rp;
      end else if (req && !imem_ack) begin
        m_kill = 1; m_target = rp;
      end else begin
        m_pc = rp;
      end
    end else begin
      if (deq) begin void'(m_qpc.pop_front()); void'(m_qins.pop_front()); end
      if (m_kill) begin
        if (imem_ack) begin m_pc = m_target; m_kill = 0; end
      end else if (req && imem_ack) begin
        m_qpc.push_back(m_pc); m_qins.push_back(imem_rdata);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] w;
    chk("imem_req", {31'b0, imem_req}, {31'b0, model_req()});
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_qpc.size() > 0});
    if (m_qpc.size() > 0) begin
      w = m_qins[0];
      chk("instr_pc", instr_pc, m_qpc[0]);
      chk("instr", instr, w);
      chk("op", {26'b0, op}, {26'b0, w[31:26]});
      chk("funct", {26'b0, funct}, {26'b0, w[5:0]});
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
  endtask

  task automatic step(input bit ack, input logic [31:0] rdata, input bit rdy, input bit rd,
                      input logic [31:0] rpc);
    imem_ack = ack; imem_rdata = rdata; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    imem_ack = 0; instr_ready = 0; redirect = 0; redirect_pc = '0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    // Power-on reset values.
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;

    // Streaming: ack every cycle, ready=1; an ack while idle is ignored.
    step(1, 32'hAAAA_0001, 1, 0, 0);
    chk("stream_first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 32'h1000_0000 + 32'(i) * 32'h0400_0041, 1, 0, 0);
    chk("stream_pc", instr_pc, 32'h14);

    // Back-pressure fills the buffer, then drains in order.
    do_reset();
    step(1, 32'h1111_1111, 0, 0, 0);
    step(1, 32'h2222_2222, 0, 0, 0);
    step(1, 32'h3333_3333, 0, 0, 0);
    step(1, 32'h4444_4444, 0, 0, 0);
    chk("full_req", {31'b0, imem_req}, 32'h0);
    chk("full_addr", imem_addr, 32'h8);
    chk("full_head", instr_pc, 32'h0);
    step(1, 32'h5555_5555, 1, 0, 0);
    chk("drain_head", instr_pc, 32'h4);
    step(1, 32'h6666_6666, 1, 0, 0);
    chk("resume_head", instr_pc, 32'h8);

    // Redirect while a request waits for its ack.
    do_reset();
    step(0, 0, 1, 0, 0);
    step(1, 32'hDEAD_0000, 1, 1, 32'h10);
    step(0, 0, 1, 1, 32'h40);
    chk("kill_addr0", imem_addr, 32'h10);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("kill_addr2", imem_addr, 32'h10);
    step(1, 32'hBAD0_BAD0, 1, 0, 0);
    chk("kill_new_addr", imem_addr, 32'h40);
    chk("kill_dropped", {31'b0, instr_valid}, 32'h0);
    step(1, 32'h0C00_0025, 1, 0, 0);
    chk("kill_first_pc", instr_pc, 32'h40);

    // Redirect flushes a full buffer and outranks the dequeue.
    do_reset();
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h20);
    step(1, 32'h0000_0020, 0, 0, 0);
    step(1, 32'h0000_0024, 0, 0, 0);
    step(0, 0, 1, 1, 32'h103);
    chk("flush_valid", {31'b0, instr_valid}, 32'h0);
    chk("flush_addr", imem_addr, 32'h100);

    // Address wrap at the top of memory.
    step(1, 0, 1, 1, 32'hFFFF_FFFF);
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    step(1, 32'hFC00_003F, 1, 0, 0);
    chk("wrap_zero", imem_addr, 32'h0);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a killed request.
    step(0, 0, 1, 1, 32'h200);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async");
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    step(1, 32'h7777_7777, 1, 0, 0);
    step(1, 32'h8888_8888, 1, 0, 0);
    chk("restart_pc", instr_pc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
